// File: rtl/note_play_sequencer.sv
// Note play sequencer: queues note codes from the converter and plays each one
// for a fixed duration followed by a silent gap, in arrival order.
module note_play_sequencer #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned CLK_PER_MS = 100000,
  parameter int unsigned NOTE_MS    = 250,
  parameter int unsigned GAP_MS     = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   key_valid,
  input  logic [4:0]             key_note,
  input  logic                   flush,
  output logic                   key_ready,
  output logic [4:0]             play_note,
  output logic                   playing,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow
);

  localparam int unsigned PtrW    = $clog2(DEPTH);
  localparam int unsigned CntW    = PtrW + 1;
  localparam int unsigned NoteCyc = NOTE_MS * CLK_PER_MS;
  localparam int unsigned GapCyc  = GAP_MS * CLK_PER_MS;
  localparam int unsigned MaxCyc  = (NoteCyc > GapCyc) ? NoteCyc : GapCyc;
  localparam int unsigned TmrW    = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

  localparam logic [TmrW-1:0] NoteLast = TmrW'(NoteCyc - 1);
  localparam logic [TmrW-1:0] GapLast  = TmrW'(GapCyc - 1);
  localparam logic [CntW-1:0] FullCnt  = CntW'(DEPTH);
  localparam logic [4:0]      MaxNote  = 5'd21;

  typedef enum logic [1:0] {
    StIdle,
    StPlay,
    StGap
  } state_e;

  state_e          state_q, state_d;
  logic [TmrW-1:0] timer_q, timer_d;
  logic [4:0]      note_q, note_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            overflow_q, overflow_d;
  logic [4:0]      mem [DEPTH];

  logic key_ok;
  logic full;
  logic empty;
  logic push;
  logic pop;
  logic note_done;
  logic gap_done;

  // Codes outside 1..21 are not notes and never reach the queue or the overflow flag.
  assign key_ok    = (key_note != 5'd0) && (key_note <= MaxNote);
  assign full      = (count_q == FullCnt);
  assign empty     = (count_q == '0);
  assign note_done = (timer_q == NoteLast);
  assign gap_done  = (timer_q == GapLast);

  assign push = key_valid && key_ok && !full && !flush;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!empty) begin
            state_d = StPlay;
          end
        end
        StPlay: begin
          if (note_done) begin
            state_d = StGap;
          end
        end
        StGap: begin
          if (gap_done) begin
            state_d = empty ? StIdle : StPlay;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM outputs and datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    playing    = (state_q == StPlay);
    pop        = 1'b0;
    timer_d    = timer_q;
    note_d     = note_q;
    overflow_d = 1'b0;

    if (!flush) begin
      pop = !empty && ((state_q == StIdle) || ((state_q == StGap) && gap_done));
      // A pop in the same cycle does not free a slot for the incoming event.
      overflow_d = key_valid && key_ok && full;
    end

    // Timer restarts on every state change and stays parked at zero in idle.
    if ((state_d != state_q) || (state_q == StIdle)) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + TmrW'(1);
    end

    if (flush) begin
      note_d = 5'd0;
    end else if (pop) begin
      note_d = mem[rd_ptr_q];
    end else if ((state_q == StPlay) && note_done) begin
      note_d = 5'd0;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO pointer and occupancy next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q    <= '0;
      note_q     <= 5'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      timer_q    <= timer_d;
      note_q     <= note_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= key_note;
    end
  end

  assign key_ready  = !full;
  assign play_note  = note_q;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_note_play_sequencer.sv
// Randomised and directed bench for note_play_sequencer against a countdown
// model of the queue-and-play behaviour.
module tb_note_play_sequencer;

  localparam int DEPTH      = 4;
  localparam int CLK_PER_MS = 4;
  localparam int NOTE_MS    = 3;
  localparam int GAP_MS     = 1;
  localparam int NOTE_CYC   = NOTE_MS * CLK_PER_MS;
  localparam int GAP_CYC    = GAP_MS * CLK_PER_MS;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       key_valid = 1'b0;
  logic [4:0] key_note = 5'd0;
  logic       flush = 1'b0;
  logic       key_ready;
  logic [4:0] play_note;
  logic       playing;
  logic [2:0] fifo_count;
  logic       overflow;

  note_play_sequencer #(
    .DEPTH      (DEPTH),
    .CLK_PER_MS (CLK_PER_MS),
    .NOTE_MS    (NOTE_MS),
    .GAP_MS     (GAP_MS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_valid  (key_valid),
    .key_note   (key_note),
    .flush      (flush),
    .key_ready  (key_ready),
    .play_note  (play_note),
    .playing    (playing),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: pending notes, note on air, and cycles left in the current note or gap.
  int q[$];
  int cur_note  = 0;
  int play_left = 0;
  int gap_left  = 0;
  bit exp_ovf   = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    cur_note  = 0;
    play_left = 0;
    gap_left  = 0;
    exp_ovf   = 1'b0;
  endtask

  task automatic model_step(input bit kv, input int kn, input bit fl);
    bit valid;
    bit full;
    bit pop;
    valid = kv && (kn != 0) && (kn <= 21);
    if (fl) begin
      model_reset();
      return;
    end
    full = (q.size() == DEPTH);
    pop  = 1'b0;
    if (play_left > 0) begin
      if (play_left == 1) begin
        play_left = 0;
        gap_left  = GAP_CYC;
      end else begin
        play_left--;
      end
    end else if (gap_left > 0) begin
      if (gap_left == 1) begin
        gap_left = 0;
        pop      = (q.size() > 0);
      end else begin
        gap_left--;
      end
    end else begin
      pop = (q.size() > 0);
    end
    if (pop) begin
      cur_note  = q.pop_front();
      play_left = NOTE_CYC;
    end
    if (valid && !full) q.push_back(kn);
    exp_ovf = valid && full;
  endtask

  task automatic check_outputs();
    check("play_note", play_note, (play_left > 0) ? cur_note : 0);
    check("playing", playing, (play_left > 0) ? 1 : 0);
    check("fifo_count", fifo_count, q.size());
    check("overflow", overflow, exp_ovf);
    check("key_ready", key_ready, (q.size() != DEPTH) ? 1 : 0);
  endtask

  // Check the state left by the previous edge, then drive inputs for the next edge.
  task automatic cycle(input bit kv, input int kn, input bit fl);
    @(negedge clk);
    check_outputs();
    key_valid = kv;
    key_note  = kn[4:0];
    flush     = fl;
    model_step(kv, kn, fl);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_play_note"}, play_note, 0);
    check({tag, "_playing"}, playing, 0);
    check({tag, "_fifo_count"}, fifo_count, 0);
    check({tag, "_overflow"}, overflow, 0);
    check({tag, "_key_ready"}, key_ready, 1);
  endtask

  initial begin
    #1 rst = 1'b1;
    @(negedge clk);
    check_reset_values("reset");
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Single note: 12 cycles of sound, 4 of silence, back to idle.
    cycle(1'b1, 5, 1'b0);
    idle(20);

    // Back-to-back keys play in order with no idle between them.
    cycle(1'b1, 1, 1'b0);
    cycle(1'b1, 2, 1'b0);
    cycle(1'b1, 3, 1'b0);
    idle(52);

    // Six keys during a note: four queue up, two overflow.
    cycle(1'b1, 7, 1'b0);
    idle(2);
    for (int i = 0; i < 6; i++) cycle(1'b1, 8 + i, 1'b0);
    idle(90);

    // Non-note codes are ignored.
    cycle(1'b1, 0, 1'b0);
    idle(2);
    cycle(1'b1, 22, 1'b0);
    idle(3);

    // Full queue: a key on the gap-to-play pop edge is still dropped.
    cycle(1'b1, 4, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 10 + i, 1'b0);
    for (int i = 0; i < 200 && gap_left != 1; i++) cycle(1'b0, 0, 1'b0);
    check("wait_gap_end", gap_left, 1);
    cycle(1'b1, 9, 1'b0);
    idle(80);

    // Flush mid-note with two queued and a simultaneous key.
    cycle(1'b1, 2, 1'b0);
    cycle(1'b1, 3, 1'b0);
    cycle(1'b1, 4, 1'b0);
    idle(5);
    cycle(1'b1, 6, 1'b1);
    idle(4);

    // Asynchronous reset during a gap, between clock edges.
    cycle(1'b1, 11, 1'b0);
    cycle(1'b1, 12, 1'b0);
    for (int i = 0; i < 200 && gap_left != 2; i++) cycle(1'b0, 0, 1'b0);
    check("wait_gap", gap_left, 2);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_values("async_rst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    model_step(1'b0, 0, 1'b0);
    idle(3);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 2500; i++) begin
      bit kv;
      bit fl;
      int kn;
      kv = ($urandom_range(0, 4) == 0);
      kn = $urandom_range(0, 23);
      fl = ($urandom_range(0, 299) == 0);
      cycle(kv, kn, fl);
    end
    idle(100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
